// File: rtl/button_step_conditioner_pkg.sv
// Shared types and helpers for the push-button step conditioner.
// Holds the debounce FSM state encoding and a counter-width helper.
package button_step_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESS_CHK = 2'd1,
      HELD      = 2'd2,
      REL_CHK   = 2'd3
   } state_e;

   // Bits needed for a counter that must hold every value 0..max_val.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/button_step_conditioner_sync_2ff.sv
// Generic two-flop synchroniser for asynchronous panel inputs.
// The output is the second flop; it resets to zero.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             input_clock1_1,
   input  logic             input_reset_n,
   input  logic [WIDTH-1:0] async_i,
   output logic [WIDTH-1:0] sync_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // NOTE: sequential state uses non-blocking assignments so both flops
   // sample the pre-edge values and form a true two-stage shift.
   always_ff @(posedge input_clock1_1 or negedge input_reset_n) begin
      if (!input_reset_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

endmodule

// File: rtl/button_step_conditioner.sv
// Debounces a raw push-button and emits one-cycle step strobes, with
// optional auto-repeat while held, a pressed level and a step counter.
module button_step_conditioner
   import button_step_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_DELAY    = 64,
   parameter int REPEAT_PERIOD   = 16,
   parameter int STEP_W          = 3
) (
   input  logic              input_clock1_1,
   input  logic              input_reset_n,
   input  logic              button_raw,
   input  logic              repeat_en,
   output logic              step_pulse,
   output logic              pressed,
   output logic [STEP_W-1:0] step_count
);

   localparam int DB_W    = cnt_width(DEBOUNCE_CYCLES - 1);
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RP_W    = cnt_width(REP_MAX);

   localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RP_W-1:0] DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
   localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);

   logic              sync;
   state_e            state_q, state_d;
   logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
   logic [RP_W-1:0]   rep_cnt_q, rep_cnt_d;
   logic              rep_first_q, rep_first_d;
   logic              pulse_q, pulse_d;
   logic              pressed_q, pressed_d;
   logic [STEP_W-1:0] count_q, count_d;
   logic [RP_W-1:0]   rep_target;

   sync_2ff #(.WIDTH(1)) u_sync (
      .input_clock1_1 (input_clock1_1),
      .input_reset_n  (input_reset_n),
      .async_i        (button_raw),
      .sync_o         (sync)
   );

   // Initial hold-off until the first repeat, then the steady period.
   assign rep_target = rep_first_q ? PERIOD_LAST : DELAY_LAST;

   // NOTE: every variable gets its default before the case so no path
   // leaves one unassigned, which would infer a latch.
   always_comb begin
      state_d     = state_q;
      db_cnt_d    = db_cnt_q;
      rep_cnt_d   = rep_cnt_q;
      rep_first_d = rep_first_q;
      pressed_d   = pressed_q;
      pulse_d     = 1'b0;
      count_d     = count_q;

      case (state_q)
         IDLE: begin
            if (sync) begin
               state_d  = PRESS_CHK;
               db_cnt_d = '0;
            end
         end
         PRESS_CHK: begin
            if (!sync) begin
               state_d  = IDLE;
               db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
               state_d     = HELD;
               pressed_d   = 1'b1;
               pulse_d     = 1'b1;
               rep_cnt_d   = '0;
               rep_first_d = 1'b0;
            end else begin
               db_cnt_d = db_cnt_q + DB_W'(1);
            end
         end
         HELD: begin
            if (!sync) begin
               state_d  = REL_CHK;
               db_cnt_d = '0;
            end else if (repeat_en) begin
               // A due repeat waits one cycle if the previous cycle pulsed,
               // keeping strobes apart even for a period or delay of 1.
               if (rep_cnt_q == rep_target) begin
                  if (!pulse_q) begin
                     pulse_d     = 1'b1;
                     rep_cnt_d   = '0;
                     rep_first_d = 1'b1;
                  end
               end else begin
                  rep_cnt_d = rep_cnt_q + RP_W'(1);
               end
            end
         end
         REL_CHK: begin
            if (sync) begin
               state_d = HELD;
            end else if (db_cnt_q == DB_LAST) begin
               state_d     = IDLE;
               pressed_d   = 1'b0;
               rep_cnt_d   = '0;
               rep_first_d = 1'b0;
            end else begin
               db_cnt_d = db_cnt_q + DB_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (pulse_d) count_d = count_q + STEP_W'(1);
   end

   always_ff @(posedge input_clock1_1 or negedge input_reset_n) begin
      if (!input_reset_n) begin
         state_q     <= IDLE;
         db_cnt_q    <= '0;
         rep_cnt_q   <= '0;
         rep_first_q <= 1'b0;
         pulse_q     <= 1'b0;
         pressed_q   <= 1'b0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         db_cnt_q    <= db_cnt_d;
         rep_cnt_q   <= rep_cnt_d;
         rep_first_q <= rep_first_d;
         pulse_q     <= pulse_d;
         pressed_q   <= pressed_d;
         count_q     <= count_d;
      end
   end

   assign step_pulse = pulse_q;
   assign pressed    = pressed_q;
   assign step_count = count_q;

endmodule

// File: tb/tb_button_step_conditioner.sv
// Directed bench for button_step_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=8, REPEAT_PERIOD=3, STEP_W=3.
module tb_button_step_conditioner;

   localparam int DB = 4;
   localparam int RD = 8;
   localparam int RP = 3;
   localparam int SW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          raw = 1'b1;
   logic          rep_en = 1'b0;
   logic          step_pulse;
   logic          pressed;
   logic [SW-1:0] step_count;

   int            total = 0;
   int            bad = 0;
   logic [SW-1:0] exp_count = '0;
   logic          prev_pulse;

   always #5 clk = ~clk;

   button_step_conditioner #(
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP),
      .STEP_W          (SW)
   ) dut (
      .input_clock1_1 (clk),
      .input_reset_n  (rst_n),
      .button_raw     (raw),
      .repeat_en      (rep_en),
      .step_pulse     (step_pulse),
      .pressed        (pressed),
      .step_count     (step_count)
   );

   // One active edge, then park on the falling edge for sampling/driving.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compares all outputs against the bench's own model of this cycle.
   task automatic check_cycle(input string tag, input int i, input logic exp_pulse,
                              input logic exp_pressed);
      if (exp_pulse) exp_count = exp_count + SW'(1);
      check($sformatf("%s[%0d].pulse", tag, i), {7'd0, step_pulse}, {7'd0, exp_pulse});
      check($sformatf("%s[%0d].pressed", tag, i), {7'd0, pressed}, {7'd0, exp_pressed});
      check($sformatf("%s[%0d].count", tag, i), {5'd0, step_count}, {5'd0, exp_count});
   endtask

   function automatic logic repeat_pulse_at(input int i);
      int edges [13] = '{7, 15, 18, 21, 24, 27, 30, 33, 36, 39, 42, 48, 51};
      logic hit = 1'b0;
      for (int k = 0; k < 13; k++) if (edges[k] == i) hit = 1'b1;
      return hit;
   endfunction

   initial begin
      // Reset held with the button pressed: all outputs stay zero.
      @(negedge clk);
      for (int i = 1; i <= 3; i++) begin
         tick();
         check_cycle("in_reset", i, 1'b0, 1'b0);
      end
      rst_n = 1'b1;
      // First edge after release samples raw=1; pulse follows edge 7.
      for (int i = 1; i <= 8; i++) begin
         tick();
         check_cycle("reset_press", i, i == 7, i >= 7);
      end
      raw = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         tick();
         check_cycle("reset_release", i, 1'b0, i < 7);
      end

      // Clean press for 6 edges, then release; pressed falls 7 edges after edge 7.
      raw = 1'b1;
      for (int i = 1; i <= 14; i++) begin
         tick();
         check_cycle("clean", i, i == 7, (i >= 7) && (i < 13));
         raw = (i < 6);
      end

      // Bounce 1,0,1,1,0 then steady low: nothing may happen.
      for (int i = 1; i <= 12; i++) begin
         case (i)
            1, 3, 4: raw = 1'b1;
            default: raw = 1'b0;
         endcase
         tick();
         check_cycle("bounce", i, 1'b0, 1'b0);
      end

      // Long hold with auto-repeat; a 2-cycle low glitch on edges 41-42
      // freezes the repeat counter for three edges, shifting 45 to 48.
      rep_en = 1'b1;
      prev_pulse = 1'b0;
      for (int i = 1; i <= 52; i++) begin
         raw = !((i == 41) || (i == 42));
         tick();
         check_cycle("repeat", i, repeat_pulse_at(i), i >= 7);
         check($sformatf("repeat[%0d].no_b2b", i), {7'd0, prev_pulse & step_pulse}, 8'd0);
         prev_pulse = step_pulse;
      end

      // Disable repeat, release: no pulses, pressed falls after edge 7.
      rep_en = 1'b0;
      raw = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         tick();
         check_cycle("repeat_release", i, 1'b0, i < 7);
      end

      // Reset mid PRESS_CHK (debounce counter at 2 after edge 5).
      raw = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         check_cycle("midpress", i, 1'b0, 1'b0);
      end
      rst_n = 1'b0;
      #1;
      exp_count = '0;
      check_cycle("async_reset", 0, 1'b0, 1'b0);
      for (int i = 1; i <= 2; i++) begin
         tick();
         check_cycle("held_reset", i, 1'b0, 1'b0);
      end
      rst_n = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         check_cycle("requalify", i, i == 7, i >= 7);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/button_step_conditioner.md
Name: button_step_conditioner

Overview:
- Upstream stage for the generated JK-flip-flop counter circuits.
- Takes a raw, bouncy push-button, synchronises and debounces it, and emits a clean one-cycle step pulse. The downstream counter consumes this pulse as its clock/clock-enable.
- Optional auto-repeat produces periodic steps while the button is held.
- Drives a debounced level for the "button pressed" LED, plus a wrapping step counter for bring-up visibility.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised samples needed to accept a press or a release. Legal range is 2 or more.
- REPEAT_DELAY, 64: held cycles after the accepted press before the first auto-repeat pulse. Legal range is 1 or more.
- REPEAT_PERIOD, 16: cycles between subsequent auto-repeat pulses. Legal range is 1 or more.
- STEP_W, 3: width of the step_count output.

Ports:
- input_clock1_1  in  1  sole clock, rising edge.
- input_reset_n  in  1  asynchronous, active-low reset.
- button_raw  in  1  asynchronous push-button level; 1 = pressed.
- repeat_en  in  1  enables auto-repeat; quasi-static, sampled every cycle.
- step_pulse  out  1  single-cycle step strobe to the downstream counter.
- pressed  out  1  debounced button level, for the LED.
- step_count  out  STEP_W  count of issued step pulses, modulo 2^STEP_W.

Behaviour:
- Reset (async assert, sync release): synchroniser flops = 0, state = IDLE, debounce and repeat counters = 0, step_pulse = 0, pressed = 0, step_count = 0.
- All outputs are registered; no combinational path from any input to any output.
- Synchroniser: 2 flops; sync = second flop. The FSM uses only sync.
- Debounce counter: width $clog2(DEBOUNCE_CYCLES).
- Repeat counter: width $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
- FSM states are IDLE, PRESS_CHK, HELD, REL_CHK:
  - IDLE: if sync = 1, go to PRESS_CHK and clear the debounce counter.
  - PRESS_CHK: if sync = 0, return to IDLE with the counter cleared; no pulse. If sync = 1 and counter = DEBOUNCE_CYCLES-1, go to HELD, set pressed = 1, pulse step_pulse, clear the repeat counter. Otherwise increment the counter.
  - HELD: if sync = 0, go to REL_CHK and clear the debounce counter; the repeat counter freezes. Otherwise, with repeat_en = 1, increment the repeat counter.
    - The first repeat pulse fires when the counter reaches REPEAT_DELAY-1; the counter then clears.
    - Later pulses fire each time the counter reaches REPEAT_PERIOD-1.
    - A flag records that the first repeat has fired.
    - With repeat_en = 0, the counter holds its value; no repeat pulses.
  - REL_CHK: if sync = 1, return to HELD; the repeat counter resumes from its frozen value and no pulse is issued (glitch rejection). If sync = 0 and counter = DEBOUNCE_CYCLES-1, go to IDLE, set pressed = 0, clear the repeat state. Otherwise increment the counter.
- Press latency: the first edge sampling button_raw = 1 is edge 1. With raw stable high, step_pulse is high for exactly one cycle after edge DEBOUNCE_CYCLES+3, and pressed rises on that same edge.
- Release latency: with raw stable low, pressed falls after edge DEBOUNCE_CYCLES+3, counted from the first edge sampling 0.
- step_pulse is never high for two consecutive cycles, for any stimulus.
- step_count increments on every cycle where step_pulse = 1, and wraps from 2^STEP_W-1 to 0.
- Bounce shorter than DEBOUNCE_CYCLES synchronised cycles, in either direction, produces no pulse and no change to pressed.
- Reset asserted mid-press returns everything to reset values immediately, with no pulse. After release of reset, a still-held button is re-qualified from IDLE and yields a fresh pulse.
- repeat_en dropping mid-repeat: no further pulses; the counter holds. Re-enabling resumes the count.

Decomposition:
- Package button_step_pkg holds:
  - the state enum (IDLE, PRESS_CHK, HELD, REL_CHK);
  - a clog2-based width helper function.
- Sub-module sync_2ff: a generic two-flop synchroniser with the same clock/reset ports. It is reused for other asynchronous panel inputs.
- Everything else sits in the top module.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3, STEP_W=3):
- Reset with button_raw = 1 held throughout: all outputs 0 during reset. After release, exactly one step_pulse 7 edges after the first sampling edge; pressed = 1; step_count = 1.
- Clean press held 6 cycles, then release, repeat_en = 0: one pulse; pressed falls 7 edges after the release sample; step_count = 1.
- Bounce pattern 1,0,1,1,0 on raw, then steady 0: no step_pulse; pressed stays 0; FSM back in IDLE.
- Hold 40 cycles with repeat_en = 1: press pulse at edge 7, then first repeat 8 cycles later, then every 3 cycles. No back-to-back pulses. step_count wraps 7 to 0 at the 9th pulse.
- While in HELD, drive a 2-cycle low glitch: no release, no extra pulse; repeat cadence continues from the frozen count.
- Assert input_reset_n mid-PRESS_CHK (counter = 2): immediate zero outputs, no pulse. Re-release with raw still 1: a fresh pulse after 7 edges.
